iob_mem_responder: RTL and testbench

- Memory-side responder for the iob_cache back-end native interface (mem_valid/mem_addr/mem_wdata/mem_wstrb → mem_rdata/mem_ready).
- Replaces the bare single-port RAM plus one-line ready register.
- Adds programmable wait states, byte-lane writes, and protocol-violation detection.
- Serves as the cache's backing store in simulation and FPGA bring-up.

---
 rtl/iob_mem_responder_pkg.sv | 14 +
 rtl/iob_be_ram.sv | 41 ++++
 rtl/iob_mem_responder.sv | 128 ++++++++++++
 tb/tb_iob_mem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/iob_mem_responder_pkg.sv
// Shared definitions for the iob_cache memory-side responder:
// FSM encoding and wait-state counter sizing.
package iob_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/iob_be_ram.sv
// Synchronous single-port RAM with per-byte write enables and a registered,
// resettable read port that holds its value when no read is requested.
module iob_be_ram #(
  parameter int IDX_W  = 12,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W/8-1:0]   we,
  input  logic                  re,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << IDX_W;

  // One byte-wide array per lane keeps each lane a plain RAM for inference.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (we[gi]) begin
        mem[addr] <= wdata[gi*8 +: 8];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lane_q <= '0;
      end else if (re) begin
        lane_q <= mem[addr];
      end
    end

    assign rdata[gi*8 +: 8] = lane_q;
  end

endmodule

// File: rtl/iob_mem_responder.sv
// Memory-side responder for the iob_cache native back-end interface with
// programmable wait states, byte-lane writes and sticky abort detection.
module iob_mem_responder
  import iob_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  output logic                  prot_err
);

  localparam int IDX_W   = ADDR_W - 2;
  localparam int NB      = DATA_W / 8;
  localparam int LAT_EFF = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT_EFF);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NB-1:0]       wstrb_q;

  logic                fire;
  logic [IDX_W-1:0]    ram_idx;
  logic [DATA_W-1:0]   ram_wdata;
  logic [NB-1:0]       ram_strb;
  logic [NB-1:0]       ram_we;
  logic                ram_re;
  logic                unused_addr;

  assign unused_addr = ^mem_addr[1:0];

  // The RAM access happens on the edge that enters RESP; with zero latency
  // that edge is the IDLE sampling edge, so the live request is used.
  always_comb begin
    fire      = 1'b0;
    ram_idx   = idx_q;
    ram_wdata = wdata_q;
    ram_strb  = wstrb_q;
    case (state)
      IDLE: begin
        ram_idx   = mem_addr[ADDR_W-1:2];
        ram_wdata = mem_wdata;
        ram_strb  = mem_wstrb;
        fire      = mem_valid && (LAT_EFF == 0);
      end
      WAIT:    fire = mem_valid && (cnt == CNT_W'(1));
      default: fire = 1'b0;
    endcase
  end

  assign ram_we = fire ? ram_strb : '0;
  assign ram_re = fire && (ram_strb == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      mem_ready <= 1'b0;
      prot_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid) begin
            idx_q   <= mem_addr[ADDR_W-1:2];
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            cnt     <= LAT_CNT;
            if (LAT_EFF == 0) begin
              state     <= RESP;
              mem_ready <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // Dropping valid before completion is an abort: no write, no ready.
          if (!mem_valid) begin
            prot_err <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
          end else if (cnt == CNT_W'(1)) begin
            state     <= RESP;
            mem_ready <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  iob_be_ram #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_idx),
    .wdata (ram_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_iob_mem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 0, 4) checked against a
// word-array memory model with byte-lane merge and spec-level timing rules.
module tb_iob_mem_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid [N];
  logic [13:0] addr  [N];
  logic [31:0] wdata [N];
  logic [3:0]  wstrb [N];
  logic [31:0] rdata [N];
  logic        ready [N];
  logic        prot  [N];

  int tests = 0;
  int fails = 0;

  logic [31:0] model   [N][4096];
  logic [31:0] last_rd [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    iob_mem_responder #(
      .ADDR_W  (14),
      .DATA_W  (32),
      .LATENCY (gi == 0 ? 2 : (gi == 1 ? 0 : 4))
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_valid (valid[gi]),
      .mem_addr  (addr[gi]),
      .mem_wdata (wdata[gi]),
      .mem_wstrb (wstrb[gi]),
      .mem_rdata (rdata[gi]),
      .mem_ready (ready[gi]),
      .prot_err  (prot[gi])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 4);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = w[b*8 +: 8];
    return r;
  endfunction

  // Runs one handshake; returns observed data, model expectation, edges to
  // ready (-1 on timeout) and the ready level one edge after the pulse.
  task automatic txn(input int d, input logic [13:0] a, input logic [31:0] w,
                     input logic [3:0] s, output logic [31:0] rd, output logic [31:0] exp,
                     output int e, output logic aft);
    exp = (s == 4'h0) ? model[d][a[13:2]] : last_rd[d];
    addr[d] = a; wdata[d] = w; wstrb[d] = s; valid[d] = 1'b1;
    e = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ready[d] === 1'b1) begin e = k; break; end
    end
    rd = rdata[d];
    valid[d] = 1'b0;
    @(posedge clk); #1;
    aft = ready[d];
    if (s == 4'h0) last_rd[d] = model[d][a[13:2]];
    else model[d][a[13:2]] = merge(model[d][a[13:2]], w, s);
    $display("[TB] dut%0d %s addr=%h wdata=%h wstrb=%h rdata=%h edges=%0d", d,
             (s == 4'h0) ? "RD" : "WR", a, w, s, rd, e);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      tests++; if (ready[d] !== 1'b0) begin fails++; $display("FAIL reset_ready dut%0d: got %b want 0", d, ready[d]); end
      tests++; if (prot[d] !== 1'b0) begin fails++; $display("FAIL reset_prot dut%0d: got %b want 0", d, prot[d]); end
      tests++; if (rdata[d] !== 32'h0) begin fails++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, rdata[d]); end
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    logic [31:0] rd, exp; int e; logic aft;
    txn(0, 14'h1234, 32'hDEADBEEF, 4'hF, rd, exp, e, aft);
    tests++; if (e != lat_of(0) + 1) begin fails++; $display("FAIL wr_latency: got %0d want %0d", e, lat_of(0) + 1); end
    tests++; if (aft !== 1'b0) begin fails++; $display("FAIL wr_pulse: got %b want 0", aft); end
    txn(0, 14'h1234, 32'h0, 4'h0, rd, exp, e, aft);
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h want DEADBEEF", rd); end
    tests++; if (e != lat_of(0) + 1) begin fails++; $display("FAIL rd_latency: got %0d want %0d", e, lat_of(0) + 1); end
    tests++; if (aft !== 1'b0) begin fails++; $display("FAIL rd_pulse: got %b want 0", aft); end
  endtask

  task automatic test_byte_strobe;
    logic [31:0] rd, exp; int e; logic aft;
    logic [31:0] w_tab [4] = '{32'h000000AA, 32'h0, 32'h11000000, 32'h0};
    logic [3:0]  s_tab [4] = '{4'b0001, 4'b0000, 4'b1000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      txn(0, 14'h1234, w_tab[i], s_tab[i], rd, exp, e, aft);
      tests++; if (rd !== exp) begin fails++; $display("FAIL strobe_data step%0d: got %h want %h", i, rd, exp); end
      tests++; if (e != lat_of(0) + 1) begin fails++; $display("FAIL strobe_latency step%0d: got %0d want %0d", i, e, lat_of(0) + 1); end
    end
    tests++; if (rd !== 32'h11ADBEAA) begin fails++; $display("FAIL strobe_final: got %h want 11ADBEAA", rd); end
  endtask

  // Holds a read valid: ready must pulse first at L+1 edges, then every L+2.
  task automatic test_back_to_back(input int d);
    logic [31:0] rd, exp; int e; logic aft; int l, kmax; logic want;
    l = lat_of(d);
    txn(d, 14'h0100, $urandom, 4'hF, rd, exp, e, aft);
    addr[d] = 14'h0100; wstrb[d] = 4'h0; valid[d] = 1'b1;
    kmax = (l + 1) + 3 * (l + 2);
    for (int k = 1; k <= kmax; k++) begin
      @(posedge clk); #1;
      want = (k >= l + 1) && (((k - l - 1) % (l + 2)) == 0);
      tests++; if (ready[d] !== want) begin fails++; $display("FAIL b2b_ready dut%0d edge%0d: got %b want %b", d, k, ready[d], want); end
      if (want) begin
        tests++; if (rdata[d] !== model[d][12'h040]) begin fails++; $display("FAIL b2b_data dut%0d edge%0d: got %h want %h", d, k, rdata[d], model[d][12'h040]); end
      end
    end
    valid[d] = 1'b0;
    last_rd[d] = model[d][12'h040];
    @(posedge clk); #1;
    $display("[TB] dut%0d back-to-back %0d edges done", d, kmax);
  endtask

  task automatic test_random(input int d);
    logic [31:0] rd, exp; int e; logic aft;
    logic [11:0] slot [6];
    logic [3:0] s;
    int i;
    for (int j = 0; j < 6; j++) begin
      slot[j] = 12'($urandom_range(1, 4094));
      txn(d, {slot[j], 2'($urandom)}, $urandom, 4'hF, rd, exp, e, aft);
      tests++; if (e != lat_of(d) + 1) begin fails++; $display("FAIL rand_init_latency dut%0d: got %0d want %0d", d, e, lat_of(d) + 1); end
    end
    for (int n = 0; n < 20; n++) begin
      i = $urandom_range(0, 5);
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      txn(d, {slot[i], 2'($urandom)}, $urandom, s, rd, exp, e, aft);
      tests++; if (rd !== exp) begin fails++; $display("FAIL rand_data dut%0d op%0d: got %h want %h", d, n, rd, exp); end
      tests++; if (e != lat_of(d) + 1) begin fails++; $display("FAIL rand_latency dut%0d op%0d: got %0d want %0d", d, n, e, lat_of(d) + 1); end
      tests++; if (aft !== 1'b0) begin fails++; $display("FAIL rand_pulse dut%0d op%0d: got %b want 0", d, n, aft); end
    end
  endtask

  task automatic test_abort;
    logic [31:0] rd, exp; int e; logic aft; logic saw;
    txn(2, 14'h0200, 32'hA5A50F0F, 4'hF, rd, exp, e, aft);
    addr[2] = 14'h0200; wdata[2] = 32'hFFFFFFFF; wstrb[2] = 4'hF; valid[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid[2] = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready[2] === 1'b1) saw = 1'b1;
    end
    $display("[TB] dut2 abort issued, ready_seen=%b prot_err=%b", saw, prot[2]);
    tests++; if (saw !== 1'b0) begin fails++; $display("FAIL abort_ready: got %b want 0", saw); end
    tests++; if (prot[2] !== 1'b1) begin fails++; $display("FAIL abort_prot: got %b want 1", prot[2]); end
    tests++; if (prot[0] !== 1'b0) begin fails++; $display("FAIL abort_other_prot: got %b want 0", prot[0]); end
    txn(2, 14'h0200, 32'h0, 4'h0, rd, exp, e, aft);
    tests++; if (rd !== 32'hA5A50F0F) begin fails++; $display("FAIL abort_data: got %h want A5A50F0F", rd); end
    tests++; if (e != lat_of(2) + 1) begin fails++; $display("FAIL abort_latency: got %0d want %0d", e, lat_of(2) + 1); end
    tests++; if (prot[2] !== 1'b1) begin fails++; $display("FAIL abort_sticky: got %b want 1", prot[2]); end
  endtask

  task automatic test_async_reset;
    logic [31:0] rd, exp; int e; logic aft;
    txn(0, 14'h1234, 32'h0, 4'h0, rd, exp, e, aft);
    addr[0] = 14'h1234; wstrb[0] = 4'h0; valid[0] = 1'b1;
    @(posedge clk); #1;
    #2;
    reset = 1'b0;
    for (int d = 0; d < N; d++) valid[d] = 1'b0;
    #1;
    $display("[TB] async reset mid-wait: ready=%b rdata=%h prot2=%b", ready[0], rdata[0], prot[2]);
    tests++; if (rdata[0] !== 32'h0) begin fails++; $display("FAIL areset_rdata: got %h want 0", rdata[0]); end
    tests++; if (ready[0] !== 1'b0) begin fails++; $display("FAIL areset_ready: got %b want 0", ready[0]); end
    tests++; if (prot[2] !== 1'b0) begin fails++; $display("FAIL areset_prot: got %b want 0", prot[2]); end
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < N; d++) last_rd[d] = 32'h0;
    @(posedge clk); #1;
    txn(0, 14'h1234, 32'h0, 4'h0, rd, exp, e, aft);
    tests++; if (rd !== 32'h11ADBEAA) begin fails++; $display("FAIL areset_read: got %h want 11ADBEAA", rd); end
    tests++; if (e != lat_of(0) + 1) begin fails++; $display("FAIL areset_latency: got %0d want %0d", e, lat_of(0) + 1); end
  endtask

  task automatic test_addr_wrap;
    logic [31:0] rd, exp; int e; logic aft;
    logic [13:0] a_tab [5] = '{14'h0000, 14'h0003, 14'h3FFC, 14'h3FFC, 14'h0000};
    logic [31:0] w_tab [5] = '{32'hCAFEEFAC, 32'h0, 32'h0BADF00D, 32'h0, 32'h0};
    logic [3:0]  s_tab [5] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0};
    for (int i = 0; i < 5; i++) begin
      txn(0, a_tab[i], w_tab[i], s_tab[i], rd, exp, e, aft);
      tests++; if (rd !== exp) begin fails++; $display("FAIL wrap_data step%0d: got %h want %h", i, rd, exp); end
      if (i == 1 || i == 4) begin
        tests++; if (rd !== 32'hCAFEEFAC) begin fails++; $display("FAIL wrap_low step%0d: got %h want CAFEEFAC", i, rd); end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int d = 0; d < N; d++) begin
      valid[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0; last_rd[d] = '0;
    end
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_back_to_back(1);
    test_back_to_back(0);
    test_back_to_back(2);
    for (int d = 0; d < N; d++) test_random(d);
    test_abort();
    test_async_reset();
    test_addr_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
